// File: rtl/operand_fwd_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module  : operand_fwd_stage_pkg
// Brief   : Shared operand-source codes and register bus type for the EX-stage
//           operand unit. The op1/op2 source codes are shared with the decoder
//           and must not be renumbered.
// Revision: 1.0 - initial release
// ============================================================================
package operand_fwd_stage_pkg;

    // Architectural register bus as seen by the rest of the core.
    typedef logic [63:0] reg_bus_t;

    // op1 source select
    localparam logic [1:0] c_op1_reg  = 2'd0;
    localparam logic [1:0] c_op1_pc   = 2'd1;
    localparam logic [1:0] c_op1_zero = 2'd2;

    // op2 source select (code 3 selects zero)
    localparam logic [1:0] c_op2_reg  = 2'd0;
    localparam logic [1:0] c_op2_imm  = 2'd1;
    localparam logic [1:0] c_op2_4    = 2'd2;

endpackage : operand_fwd_stage_pkg
`default_nettype wire

// File: rtl/operand_fwd_stage_fwd_select.sv
`default_nettype none
// ============================================================================
// Module  : operand_fwd_stage_fwd_select
// Brief   : Combinational bypass resolver for one source register.
//           Source 0 is the youngest producer; the lowest-index match wins.
//           Register x0 always resolves to zero and never hits.
// Ports   : rs_addr     - source register index
//           rf_data     - register-file read data (used when nothing matches)
//           fwd_valid   - per-source "writes fwd_addr" flag
//           fwd_pending - per-source "result not yet available" flag
//           fwd_addr    - packed destination indices, source i at [i*W +: W]
//           fwd_data    - packed results, source i at [i*XLEN +: XLEN]
//           data        - resolved operand value
//           hit         - a bypass source supplied the value
//           pending     - the winning source has no result yet
// Revision: 1.0 - initial release
// ============================================================================
module operand_fwd_stage_fwd_select #(
    parameter int XLEN       = 64,
    parameter int NUM_FWD    = 3,
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0]         rs_addr,
    input  logic [XLEN-1:0]               rf_data,
    input  logic [NUM_FWD-1:0]            fwd_valid,
    input  logic [NUM_FWD-1:0]            fwd_pending,
    input  logic [NUM_FWD*REG_ADDR_W-1:0] fwd_addr,
    input  logic [NUM_FWD*XLEN-1:0]       fwd_data,
    output logic [XLEN-1:0]               data,
    output logic                          hit,
    output logic                          pending
);

    always_comb begin
        data    = rf_data;
        hit     = 1'b0;
        pending = 1'b0;
        // Walk oldest to youngest so a younger match overwrites an older one;
        // a non-pending older match therefore cannot hide a pending younger one.
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (fwd_valid[i] && (fwd_addr[i*REG_ADDR_W +: REG_ADDR_W] == rs_addr)) begin
                data    = fwd_data[i*XLEN +: XLEN];
                hit     = 1'b1;
                pending = fwd_pending[i];
            end
        end
        // x0 is hardwired to zero regardless of what any producer claims.
        if (rs_addr == '0) begin
            data    = '0;
            hit     = 1'b0;
            pending = 1'b0;
        end
    end

endmodule : operand_fwd_stage_fwd_select
`default_nettype wire

// File: rtl/operand_fwd_stage.sv
`default_nettype none
// ============================================================================
// Module  : operand_fwd_stage
// Brief   : EX-stage operand unit. Resolves rs1/rs2 through NUM_FWD bypass
//           sources, selects op1/op2 by source code and registers them in a
//           1-entry valid/ready pipeline register feeding the ALU. Stalls
//           decode while a used operand's winning producer is still pending.
// Ports   : clock/reset            - clock, synchronous active-high reset
//           flush                  - kill held and incoming operation
//           in_valid/in_ready      - decode handshake
//           rs1/rs2_addr, rs1/rs2_data, imm, pc, op1_src, op2_src - operation
//           fwd_valid/pending/addr/data - bypass sources, 0 = youngest
//           out_valid/out_ready    - ALU handshake
//           op1, op2, store_data   - registered operands
//           stall_cnt, fwd_hit_cnt - saturating statistics (OPERAND_FWD_STAT_EN)
// Config  : define OPERAND_FWD_STAT_EN to add the statistics counters/ports.
// Revision: 1.0 - initial release
// ============================================================================
module operand_fwd_stage
    import operand_fwd_stage_pkg::*;
#(
    parameter int XLEN       = 64,
    parameter int NUM_FWD    = 3,
    parameter int REG_ADDR_W = 5
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [REG_ADDR_W-1:0]         rs1_addr,
    input  logic [REG_ADDR_W-1:0]         rs2_addr,
    input  logic [XLEN-1:0]               rs1_data,
    input  logic [XLEN-1:0]               rs2_data,
    input  logic [XLEN-1:0]               imm,
    input  logic [XLEN-1:0]               pc,
    input  logic [1:0]                    op1_src,
    input  logic [1:0]                    op2_src,
    input  logic [NUM_FWD-1:0]            fwd_valid,
    input  logic [NUM_FWD-1:0]            fwd_pending,
    input  logic [NUM_FWD*REG_ADDR_W-1:0] fwd_addr,
    input  logic [NUM_FWD*XLEN-1:0]       fwd_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [XLEN-1:0]               op1,
    output logic [XLEN-1:0]               op2,
    output logic [XLEN-1:0]               store_data
`ifdef OPERAND_FWD_STAT_EN
    ,
    output logic [31:0]                   stall_cnt,
    output logic [31:0]                   fwd_hit_cnt
`endif
);

    localparam logic [XLEN-1:0] c_four = XLEN'(4);

    logic [XLEN-1:0] w_rs1_val;
    logic [XLEN-1:0] w_rs2_val;
    logic            w_rs1_hit;
    logic            w_rs2_hit;
    logic            w_rs1_pend;
    logic            w_rs2_pend;
    logic            w_op1_uses_rs1;
    logic            w_hazard;
    logic            w_accept;
    logic [XLEN-1:0] w_op1_next;
    logic [XLEN-1:0] w_op2_next;

    logic            r_out_valid;
    logic [XLEN-1:0] r_op1;
    logic [XLEN-1:0] r_op2;
    logic [XLEN-1:0] r_store_data;

    operand_fwd_stage_fwd_select #(
        .XLEN       (XLEN),
        .NUM_FWD    (NUM_FWD),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_sel_rs1 (
        .rs_addr     (rs1_addr),
        .rf_data     (rs1_data),
        .fwd_valid   (fwd_valid),
        .fwd_pending (fwd_pending),
        .fwd_addr    (fwd_addr),
        .fwd_data    (fwd_data),
        .data        (w_rs1_val),
        .hit         (w_rs1_hit),
        .pending     (w_rs1_pend)
    );

    operand_fwd_stage_fwd_select #(
        .XLEN       (XLEN),
        .NUM_FWD    (NUM_FWD),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_sel_rs2 (
        .rs_addr     (rs2_addr),
        .rf_data     (rs2_data),
        .fwd_valid   (fwd_valid),
        .fwd_pending (fwd_pending),
        .fwd_addr    (fwd_addr),
        .fwd_data    (fwd_data),
        .data        (w_rs2_val),
        .hit         (w_rs2_hit),
        .pending     (w_rs2_pend)
    );

    // rs2 is always consumed because store_data carries it independently of
    // op2_src, so a pending rs2 producer stalls every operation.
    assign w_op1_uses_rs1 = (op1_src == c_op1_reg);
    assign w_hazard       = (w_op1_uses_rs1 && w_rs1_pend) || w_rs2_pend;
    assign in_ready       = !reset && !flush && !w_hazard && (!r_out_valid || out_ready);
    assign w_accept       = in_valid && in_ready;

    always_comb begin
        w_op1_next = '0;
        case (op1_src)
            c_op1_reg:  w_op1_next = w_rs1_val;
            c_op1_pc:   w_op1_next = pc;
            c_op1_zero: w_op1_next = '0;
            default:    w_op1_next = '0;
        endcase
    end

    always_comb begin
        w_op2_next = '0;
        case (op2_src)
            c_op2_reg: w_op2_next = w_rs2_val;
            c_op2_imm: w_op2_next = imm;
            c_op2_4:   w_op2_next = c_four;
            default:   w_op2_next = '0;
        endcase
    end

    // Flush only drops valid; the data registers keep their last values.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_out_valid  <= 1'b0;
            r_op1        <= '0;
            r_op2        <= '0;
            r_store_data <= '0;
        end else if (flush) begin
            r_out_valid  <= 1'b0;
        end else if (w_accept) begin
            r_out_valid  <= 1'b1;
            r_op1        <= w_op1_next;
            r_op2        <= w_op2_next;
            r_store_data <= w_rs2_val;
        end else if (out_ready) begin
            r_out_valid  <= 1'b0;
        end
    end

    assign out_valid  = r_out_valid;
    assign op1        = r_op1;
    assign op2        = r_op2;
    assign store_data = r_store_data;

`ifdef OPERAND_FWD_STAT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_fwd_hit_cnt;
    logic        w_used_hit;

    assign w_used_hit = (w_op1_uses_rs1 && w_rs1_hit) || w_rs2_hit;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_stall_cnt   <= '0;
            r_fwd_hit_cnt <= '0;
        end else begin
            if (in_valid && w_hazard && !flush && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (w_accept && w_used_hit && (r_fwd_hit_cnt != '1)) begin
                r_fwd_hit_cnt <= r_fwd_hit_cnt + 32'd1;
            end
        end
    end

    assign stall_cnt   = r_stall_cnt;
    assign fwd_hit_cnt = r_fwd_hit_cnt;
`else
    // Hit flags only feed the statistics counters.
    logic w_unused_hit;
    assign w_unused_hit = w_rs1_hit | w_rs2_hit;
`endif

endmodule : operand_fwd_stage
`default_nettype wire
